// File: rtl/nn_pkg.sv
// Shared definitions for the layer initializer, neurons and the weight read-back path.
package nn_pkg;

  localparam int NN_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width that stays at least one bit so single-entry dimensions still get a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_index_counter.sv
// Nested weight/neuron index counter: weight index is the fast dimension, stops at the last pair.
module weight_index_counter
  import nn_pkg::*;
#(
  parameter  int N_NEURONS = 3,
  parameter  int N_WEIGHTS = 2,
  localparam int NI_W      = clog2_min1(N_NEURONS),
  localparam int WI_W      = clog2_min1(N_WEIGHTS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [NI_W-1:0] ni_o,
  output logic [WI_W-1:0] wi_o,
  output logic            last_o
);

  logic [NI_W-1:0] ni_q, ni_d;
  logic [WI_W-1:0] wi_q, wi_d;
  logic            wi_max;
  logic            ni_max;

  assign wi_max = (wi_q == WI_W'(N_WEIGHTS - 1));
  assign ni_max = (ni_q == NI_W'(N_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ni_q <= '0;
      wi_q <= '0;
    end else begin
      ni_q <= ni_d;
      wi_q <= wi_d;
    end
  end

  // Holding at the final pair keeps both indices inside their ranges.
  always_comb begin
    ni_d = ni_q;
    wi_d = wi_q;
    if (clr_i) begin
      ni_d = '0;
      wi_d = '0;
    end else if (en_i && !last_o) begin
      if (wi_max) begin
        wi_d = '0;
        ni_d = ni_q + NI_W'(1);
      end else begin
        wi_d = wi_q + WI_W'(1);
      end
    end
  end

  assign ni_o   = ni_q;
  assign wi_o   = wi_q;
  assign last_o = ni_max && wi_max;

endmodule

// File: rtl/layer_weight_reader.sv
// Snapshots all weights of one layer on start and streams them out neuron-major over valid/ready.
module layer_weight_reader
  import nn_pkg::*;
#(
  parameter  int N_NEURONS = 3,
  parameter  int N_WEIGHTS = 2,
  parameter  int WIDTH     = NN_WIDTH,
  localparam int NI_W      = clog2_min1(N_NEURONS),
  localparam int WI_W      = clog2_min1(N_WEIGHTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [N_NEURONS*N_WEIGHTS*WIDTH-1:0] weights_flat,
  output logic [WIDTH-1:0]                   out_data,
  output logic [NI_W-1:0]                    out_neuron,
  output logic [WI_W-1:0]                    out_weight,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int N_WORDS = N_NEURONS * N_WEIGHTS;

  state_e                    state_q, state_d;
  logic [N_WORDS*WIDTH-1:0]  buf_q;
  logic [NI_W-1:0]           ni;
  logic [WI_W-1:0]           wi;
  logic                      idx_last;
  logic                      snap;
  logic                      advance;
  int                        word_idx;

  assign snap    = (state_q == IDLE) && start;
  assign advance = (state_q == SCAN) && out_ready;

  weight_index_counter #(
    .N_NEURONS (N_NEURONS),
    .N_WEIGHTS (N_WEIGHTS)
  ) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (snap),
    .en_i   (advance),
    .ni_o   (ni),
    .wi_o   (wi),
    .last_o (idx_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The snapshot decouples the stream from later changes on weights_flat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (snap) begin
      buf_q <= weights_flat;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    out_data   = '0;
    out_neuron = '0;
    out_weight = '0;
    word_idx   = int'(ni) * N_WEIGHTS + int'(wi);
    case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        out_valid  = 1'b1;
        busy       = 1'b1;
        out_last   = idx_last;
        out_data   = buf_q[word_idx*WIDTH +: WIDTH];
        out_neuron = ni;
        out_weight = wi;
        if (out_ready && idx_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_weight_reader.sv
// Directed bench for layer_weight_reader: 3x2 dump scenarios plus a 1x1 instance.
`timescale 1ns/1ps
module tb_layer_weight_reader;

  localparam int NN = 3;
  localparam int NW = 2;
  localparam int W  = 32;

  typedef struct {
    logic [W-1:0] data;
    int           n;
    int           w;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start, out_ready;
  logic [NN*NW*W-1:0] weights_flat;
  logic [W-1:0]       out_data;
  logic [1:0]         out_neuron;
  logic [0:0]         out_weight;
  logic               out_valid, out_last, busy, done;

  logic               start1, ready1;
  logic [W-1:0]       w1, data1;
  logic [0:0]         n1, wi1;
  logic               valid1, last1, busy1, done1;

  layer_weight_reader #(.N_NEURONS(NN), .N_WEIGHTS(NW), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .weights_flat(weights_flat),
    .out_data(out_data), .out_neuron(out_neuron), .out_weight(out_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  layer_weight_reader #(.N_NEURONS(1), .N_WEIGHTS(1), .WIDTH(W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .weights_flat(w1),
    .out_data(data1), .out_neuron(n1), .out_weight(wi1),
    .out_valid(valid1), .out_ready(ready1), .out_last(last1),
    .busy(busy1), .done(done1)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [W-1:0] exp1_q[$];
  int   busy_cyc = 0;
  int   done_cnt = 0;
  int   done1_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [NN*NW*W-1:0] pattern();
    logic [NN*NW*W-1:0] v;
    v = '0;
    for (int n = 0; n < NN; n++)
      for (int w = 0; w < NW; w++)
        v[((n*NW)+w)*W +: W] = W'((n+1)*16 + w + 1);
    return v;
  endfunction

  task automatic push_all();
    for (int n = 0; n < NN; n++)
      for (int w = 0; w < NW; w++)
        exp_q.push_back('{data: W'((n+1)*16 + w + 1), n: n, w: w,
                          last: (n == NN-1) && (w == NW-1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int prev, input string name);
    int k;
    k = 0;
    while (done_cnt == prev && k < 40) begin
      tick();
      k++;
    end
    if (done_cnt == prev) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done pulse within 40 cycles", name);
    end
  endtask

  // Monitor: pops expected words on each handshake, tracks done, stalls and busy.
  initial begin
    exp_t         e;
    logic         pend_done, pend_done1, prev_stall;
    logic [W-1:0] p_data;
    logic [1:0]   p_n;
    logic [0:0]   p_w;
    logic         p_last;
    pend_done = 0; pend_done1 = 0; prev_stall = 0;
    p_data = '0; p_n = '0; p_w = '0; p_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 0; pend_done1 = 0; prev_stall = 0;
      end else begin
        check("busy_eq_valid", busy, out_valid);
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (pend_done) begin
          check("done_pulse", done, 1);
          check("valid_in_done", out_valid, 0);
          check("last_in_done", out_last, 0);
          pend_done = 0;
        end else begin
          check("no_stray_done", done, 0);
        end
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, p_data);
          check("stall_neuron", out_neuron, p_n);
          check("stall_weight", out_weight, p_w);
          check("stall_last", out_last, p_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h, expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("word_data", out_data, e.data);
            check("word_neuron", out_neuron, e.n);
            check("word_weight", out_weight, e.w);
            check("word_last", out_last, e.last);
            if (e.last) pend_done = 1;
          end
        end
        prev_stall = out_valid && !out_ready;
        p_data = out_data; p_n = out_neuron; p_w = out_weight; p_last = out_last;

        if (done1) done1_cnt++;
        if (pend_done1) begin
          check("done1_pulse", done1, 1);
          pend_done1 = 0;
        end else begin
          check("no_stray_done1", done1, 0);
        end
        if (valid1 && ready1) begin
          if (exp1_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word1: got 0x%0h, expected none", data1);
          end else begin
            check("w1_data", data1, exp1_q.pop_front());
            check("w1_last", last1, 1);
            check("w1_neuron", n1, 0);
            check("w1_weight", wi1, 0);
            pend_done1 = 1;
          end
        end
      end
    end
  end

  initial begin
    int d0;
    rst = 1; start = 0; out_ready = 0; weights_flat = pattern();
    start1 = 0; ready1 = 0; w1 = 32'hA5;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_neuron", out_neuron, 0);
    check("rst_weight", out_weight, 0);
    check("rst_valid1", valid1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();

    // Basic dump with ready held high.
    push_all(); busy_cyc = 0; d0 = done_cnt;
    out_ready = 1; start = 1; tick(); start = 0;
    check("first_valid", out_valid, 1);
    check("first_data", out_data, 32'h11);
    wait_done(d0, "basic_done");
    check("busy_cycles", busy_cyc, 6);
    tick();
    check("basic_idle_valid", out_valid, 0);
    check("basic_drained", exp_q.size(), 0);

    // Backpressure on word (1,0).
    push_all(); d0 = done_cnt;
    start = 1; tick(); start = 0;
    tick(); tick();
    out_ready = 0;
    repeat (3) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h21);
      check("bp_neuron", out_neuron, 1);
      check("bp_weight", out_weight, 0);
    end
    out_ready = 1;
    wait_done(d0, "bp_done");
    tick();

    // Input changes after the snapshot.
    push_all(); d0 = done_cnt;
    start = 1; tick(); start = 0;
    weights_flat = '1;
    wait_done(d0, "snap_done");
    weights_flat = pattern();
    tick();

    // Start pulses during SCAN and DONE.
    push_all(); d0 = done_cnt;
    start = 1; tick(); start = 0;
    tick(); tick();
    start = 1; tick(); start = 0;
    tick(); tick();
    start = 1; tick(); tick(); start = 0;
    repeat (3) tick();
    check("ign_done_count", done_cnt, d0 + 1);
    check("ign_idle_valid", out_valid, 0);
    check("ign_idle_busy", busy, 0);
    check("ign_drained", exp_q.size(), 0);

    // Asynchronous reset while word (1,1) is presented.
    push_all(); d0 = done_cnt;
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    out_ready = 0;
    check("pre_rst_data", out_data, 32'h22);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_data", out_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0; out_ready = 1;
    repeat (3) tick();
    check("abort_no_done", done_cnt, d0);
    check("abort_idle_valid", out_valid, 0);
    push_all(); d0 = done_cnt;
    start = 1; tick(); start = 0;
    check("restart_data", out_data, 32'h11);
    check("restart_neuron", out_neuron, 0);
    check("restart_weight", out_weight, 0);
    wait_done(d0, "restart_done");
    tick();

    // Single-word layer.
    exp1_q.push_back(32'hA5);
    ready1 = 1; start1 = 1; tick(); start1 = 0;
    check("one_valid", valid1, 1);
    check("one_last", last1, 1);
    check("one_data", data1, 32'hA5);
    tick();
    check("one_done", done1, 1);
    check("one_done_valid", valid1, 0);
    tick();
    check("one_done_end", done1, 0);
    check("one_done_count", done1_cnt, 1);
    check("one_drained", exp1_q.size(), 0);

    repeat (2) tick();
    check("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_weight_reader.md
Name: layer_weight_reader

Overview:
- Read-back counterpart of the layer initializer. The initializer loads per-neuron weight registers sequentially; this block reads them out.
- On `start`, it snapshots every weight of one layer into an internal buffer.
- It then streams the weights out one word at a time over a valid/ready interface, in neuron-major order.
- Used by the neuron tester to dump and check layer weights after initialization.

Parameters:
- N_NEURONS, 3, number of neurons in the layer (>=1)
- N_WEIGHTS, 2, weights per neuron (>=1)
- WIDTH, 32, bits per weight
- NI_W, max(1, clog2(N_NEURONS)), neuron index width (derived, localparam)
- WI_W, max(1, clog2(N_WEIGHTS)), weight index width (derived, localparam)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a snapshot and dump; sampled only in IDLE
- weights_flat  in  N_NEURONS*N_WEIGHTS*WIDTH  all layer weights
  - word (n,w) is at bit offset ((n*N_WEIGHTS)+w)*WIDTH
- out_data  out  WIDTH  current weight word
- out_neuron  out  NI_W  neuron index of out_data
- out_weight  out  WI_W  weight index of out_data
- out_valid  out  1  out_data/indices valid
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- out_last  out  1  high with the final word (N_NEURONS-1, N_WEIGHTS-1)
- busy  out  1  high in SCAN
- done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (async, rst=1), effective immediately:
  - state=IDLE; both counters = 0; buffer cleared to 0
  - out_valid=0, out_last=0, busy=0, done=0
  - out_data=0, out_neuron=0, out_weight=0
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge T: buffer <= weights_flat; ni=0; wi=0; state -> SCAN.
  - From T+1: out_valid=1, busy=1, word (0,0) presented (start-to-first-valid latency 1 cycle).
- SCAN:
  - Outputs are driven from the registered counters and buffer:
    - out_data = buf[ni][wi]
    - out_last = (ni==N_NEURONS-1 && wi==N_WEIGHTS-1)
  - Handshake (out_valid & out_ready at an edge), not last:
    - wi increments.
    - When wi==N_WEIGHTS-1, wi wraps to 0 and ni increments.
    - The next word is visible the following cycle. Throughput is 1 word/cycle with out_ready held high.
  - Handshake on the last word: state -> DONE.
  - No handshake: all outputs hold stable (data, indices, last). out_valid never drops while in SCAN.
- DONE:
  - One cycle only: done=1, out_valid=0, busy=0, out_last=0.
  - Then -> IDLE.
- start in SCAN or DONE is ignored (no restart, no re-snapshot).
- weights_flat changes after the snapshot do not affect the stream.
- Total words per dump: N_NEURONS*N_WEIGHTS.
  - Minimum cycles from start edge to done: N_NEURONS*N_WEIGHTS+1.
- Degenerate N_NEURONS=1 and/or N_WEIGHTS=1:
  - Indices stay 0.
  - For 1x1, out_last=1 on the first word.
- Reset asserted mid-SCAN aborts the stream at once: out_valid=0 and no done pulse. A fresh start is required afterwards.
- Counters never exceed their maxima; no wrap beyond the last word.

Decomposition:
- Shared package (nn_pkg):
  - index-width function clog2_min1
  - state enum {IDLE, SCAN, DONE}
  - default WIDTH constant, shared with initializer and neurons
- One natural sub-module: weight_index_counter.
  - Nested wi/ni counter with enable, wrap, and last flag.
  - Reusable by the initializer for its per-neuron write counters.
- Buffer and FSM stay in the top module.

Test Plan:
- Basic dump, defaults, out_ready=1:
  - Stimulus: weights (0,0)=0x11, (0,1)=0x12, (1,0)=0x21, (1,1)=0x22, (2,0)=0x31, (2,1)=0x32; start pulse.
  - Response: 6 consecutive valid words in that order with correct indices; out_last only on 0x32; done exactly 1 cycle after the 0x32 handshake; busy high for 6 cycles.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles on word (1,0).
  - Response: out_data=0x21, out_neuron=1, out_weight=0, out_valid=1 held stable; the stream resumes with 0x22 after ready rises; no word skipped or duplicated.
- Snapshot isolation:
  - Stimulus: change all weights_flat words to 0xFFFFFFFF one cycle after start.
  - Response: the stream still outputs the original 0x11..0x32.
- Ignored start:
  - Stimulus: pulse start during SCAN (word 2) and during DONE.
  - Response: the stream is unaffected; exactly one done pulse; block returns to IDLE with out_valid=0.
- Async reset mid-stream:
  - Stimulus: assert rst between edges while word (1,1) is presented.
  - Response: out_valid, busy and done go 0 without waiting for a clock edge; a subsequent start restarts at (0,0).
- Parameter corner N_NEURONS=1, N_WEIGHTS=1:
  - Stimulus: weight 0xA5; start.
  - Response: single word 0xA5 with out_last=1; done on the next cycle.
